// File: rtl/tx_pkg.sv
// tx_pkg -- shared types and helpers for the UART transmit serializer.
//   tx_state_e   : serializer FSM states (PARITY is only reachable when the
//                  TX_SERIALIZER_PARITY_EN macro is defined)
//   IDLE_LEVEL   : serial line level while no frame is in progress
//   calc_parity  : parity of a word, zero-extended to PAR_MAX_W bits
package tx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } tx_state_e;

  localparam logic IDLE_LEVEL = 1'b1;

  // Zero extension does not change XOR parity, so one fixed-width helper
  // serves every DATA_WIDTH up to this size.
  localparam int PAR_MAX_W = 64;

  function automatic logic calc_parity(input logic [PAR_MAX_W-1:0] word,
                                       input logic                 odd);
    return (^word) ^ odd;
  endfunction

endpackage

// File: rtl/tx_ser_bit_counter.sv
// tx_ser_bit_counter -- bit index within the current data word.
//   CLK, RST : clock, asynchronous active-high reset
//   i_clr    : restart at bit 0 (word loaded into shifter); wins over i_adv
//   i_adv    : advance one bit; held at the last bit, never wraps
//   o_last   : counter is on bit DATA_WIDTH-1
module tx_ser_bit_counter
  import tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic CLK,
  input  logic RST,
  input  logic i_clr,
  input  logic i_adv,
  output logic o_last
);

  localparam int CNT_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_WIDTH - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                  r_cnt <= '0;
    else if (i_clr)           r_cnt <= '0;
    else if (i_adv && !o_last) r_cnt <= r_cnt + 1'b1;
  end

  assign o_last = (r_cnt == LAST_IDX);

endmodule

// File: rtl/tx_serializer_buf.sv
// tx_serializer_buf -- buffered parallel-to-serial converter, UART TX path.
// A one-entry holding register queues the next word while the current one
// shifts, so consecutive frames leave no idle bit between them.
//   CLK, RST    : clock, asynchronous active-high reset
//   P_DATA      : parallel word, captured when data_valid & data_ready
//   data_valid  : P_DATA valid
//   data_ready  : holding register empty
//   ser_en      : bit-advance strobe (baud tick), ignored while idle
//   ser_data    : serial bit, 1 when idle
//   ser_busy    : frame in progress
//   ser_done    : one-cycle pulse after the strobe that ends a frame
// Optional feature: define TX_SERIALIZER_PARITY_EN to append a parity bit
// (even when PAR_ODD=0, odd when PAR_ODD=1) after the data bits.
module tx_serializer_buf
  import tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int MSB_FIRST  = 0,
  parameter int PAR_ODD    = 0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  data_valid,
  output logic                  data_ready,
  input  logic                  ser_en,
  output logic                  ser_data,
  output logic                  ser_busy,
  output logic                  ser_done
);

  tx_state_e             r_state, w_state_nxt;
  logic [DATA_WIDTH-1:0] r_hold, r_shift;
  logic                  r_hold_full, r_done;
  logic                  w_accept, w_load, w_clr, w_adv, w_shift, w_eof;
  logic                  w_last, w_cur_bit;

  assign w_accept = data_valid & ~r_hold_full;

  // ---------------- holding register ----------------
  // accept and load never coincide: accept needs the hold empty, load full.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_hold      <= '0;
      r_hold_full <= 1'b0;
    end else if (w_accept) begin
      r_hold      <= P_DATA;
      r_hold_full <= 1'b1;
    end else if (w_load) begin
      r_hold_full <= 1'b0;
    end
  end

  // ---------------- shifter ----------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)          r_shift <= '0;
    else if (w_load)  r_shift <= r_hold;
    else if (w_shift) r_shift <= (MSB_FIRST != 0) ? {r_shift[DATA_WIDTH-2:0], 1'b0}
                                                  : {1'b0, r_shift[DATA_WIDTH-1:1]};
  end

  assign w_cur_bit = (MSB_FIRST != 0) ? r_shift[DATA_WIDTH-1] : r_shift[0];

`ifdef TX_SERIALIZER_PARITY_EN
  logic r_par;
  // Parity is taken from the hold register as it moves into the shifter,
  // so it reflects the whole word before any bit is shifted out.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)         r_par <= 1'b0;
    else if (w_load) r_par <= calc_parity(PAR_MAX_W'(r_hold), PAR_ODD != 0);
  end
`else
  logic w_unused_par_odd;
  assign w_unused_par_odd = (PAR_ODD != 0);
`endif

  tx_ser_bit_counter #(.DATA_WIDTH(DATA_WIDTH)) u_cnt (
    .CLK    (CLK),
    .RST    (RST),
    .i_clr  (w_clr),
    .i_adv  (w_adv),
    .o_last (w_last)
  );

  // ---------------- FSM ----------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_eof;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_clr       = 1'b0;
    w_adv       = 1'b0;
    w_shift     = 1'b0;
    w_eof       = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_hold_full) begin
          w_load      = 1'b1;
          w_clr       = 1'b1;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (ser_en) begin
          if (!w_last) begin
            w_shift = 1'b1;
            w_adv   = 1'b1;
          end else begin
`ifdef TX_SERIALIZER_PARITY_EN
            w_state_nxt = PARITY;
`else
            w_eof = 1'b1;
`endif
          end
        end
      end
`ifdef TX_SERIALIZER_PARITY_EN
      PARITY: begin
        if (ser_en) w_eof = 1'b1;
      end
`endif
      default: w_state_nxt = IDLE;
    endcase
    // End of frame: chain straight into the queued word if there is one,
    // so its first bit follows the last bit with no idle gap.
    if (w_eof) begin
      if (r_hold_full) begin
        w_load      = 1'b1;
        w_clr       = 1'b1;
        w_state_nxt = SHIFT;
      end else begin
        w_state_nxt = IDLE;
      end
    end
  end

  // ---------------- outputs ----------------
  always_comb begin
    ser_data = IDLE_LEVEL;
    case (r_state)
      SHIFT:   ser_data = w_cur_bit;
`ifdef TX_SERIALIZER_PARITY_EN
      PARITY:  ser_data = r_par;
`endif
      default: ser_data = IDLE_LEVEL;
    endcase
  end

  assign ser_busy   = (r_state != IDLE);
  assign ser_done   = r_done;
  assign data_ready = ~r_hold_full;

endmodule

// File: tb/tb_tx_serializer_buf.sv
// tb_tx_serializer_buf -- directed self-checking bench for tx_serializer_buf.
// Four instances share every input: dut0 (W=8, LSB first, even parity),
// dut1 (W=8, MSB first), dut2 (W=5, LSB first), dut3 (W=8, LSB first, odd
// parity). Each scenario watches the instances that matter to it.
// Parity expectations follow TX_SERIALIZER_PARITY_EN.
module tb_tx_serializer_buf;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] P_DATA = 8'h00;
  logic       data_valid = 1'b0;
  logic       ser_en = 1'b0;

  logic rdy0, sd0, bz0, dn0;
  logic rdy1, sd1, bz1, dn1;
  logic rdy2, sd2, bz2, dn2;
  logic rdy3, sd3, bz3, dn3;

  int errs = 0;
  int checks = 0;
  int dn_cnt0 = 0;

  always #5 CLK = ~CLK;

  tx_serializer_buf #(.DATA_WIDTH(8), .MSB_FIRST(0), .PAR_ODD(0)) dut0 (
    .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .data_valid(data_valid), .data_ready(rdy0),
    .ser_en(ser_en), .ser_data(sd0), .ser_busy(bz0), .ser_done(dn0));
  tx_serializer_buf #(.DATA_WIDTH(8), .MSB_FIRST(1), .PAR_ODD(0)) dut1 (
    .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .data_valid(data_valid), .data_ready(rdy1),
    .ser_en(ser_en), .ser_data(sd1), .ser_busy(bz1), .ser_done(dn1));
  tx_serializer_buf #(.DATA_WIDTH(5), .MSB_FIRST(0), .PAR_ODD(0)) dut2 (
    .CLK(CLK), .RST(RST), .P_DATA(P_DATA[4:0]), .data_valid(data_valid), .data_ready(rdy2),
    .ser_en(ser_en), .ser_data(sd2), .ser_busy(bz2), .ser_done(dn2));
  tx_serializer_buf #(.DATA_WIDTH(8), .MSB_FIRST(0), .PAR_ODD(1)) dut3 (
    .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .data_valid(data_valid), .data_ready(rdy3),
    .ser_en(ser_en), .ser_data(sd3), .ser_busy(bz3), .ser_done(dn3));

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
    if (dn0) dn_cnt0++;
  endtask

  task automatic strobe(input int wait_cycles);
    repeat (wait_cycles) tick();
    ser_en = 1'b1;
    tick();
    ser_en = 1'b0;
  endtask

  task automatic load(input logic [7:0] word);
    P_DATA     = word;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
  endtask

  task automatic do_reset();
    ser_en     = 1'b0;
    data_valid = 1'b0;
    RST        = 1'b1;
    tick();
    RST        = 1'b0;
    tick();
    dn_cnt0    = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #2 RST = 1'b1;
    #2;
    checks++; if (sd0 !== 1'b1) begin errs++; $display("FAIL rst_ser_data got %b exp 1", sd0); end
    checks++; if (bz0 !== 1'b0) begin errs++; $display("FAIL rst_busy got %b exp 0", bz0); end
    checks++; if (dn0 !== 1'b0) begin errs++; $display("FAIL rst_done got %b exp 0", dn0); end
    checks++; if (rdy0 !== 1'b1) begin errs++; $display("FAIL rst_ready got %b exp 1", rdy0); end
    tick();
    RST = 1'b0;
    repeat (3) tick();
    checks++; if (bz0 !== 1'b0 || sd0 !== 1'b1) begin errs++; $display("FAIL rst_release_idle got busy=%b sd=%b exp 0/1", bz0, sd0); end
  endtask

  // seq_l / seq_m: bit i is the i-th bit expected on the line (LSB / MSB dut)
  task automatic test_bit_order(input logic [7:0] word, input logic [7:0] seq_l, input logic [7:0] seq_m);
    do_reset();
    load(word);
    checks++; if (rdy0 !== 1'b0 || rdy1 !== 1'b0) begin errs++; $display("FAIL order_ready_low got %b%b exp 00", rdy0, rdy1); end
    checks++; if (bz0 !== 1'b0 || sd0 !== 1'b1) begin errs++; $display("FAIL order_latency got busy=%b sd=%b exp 0/1", bz0, sd0); end
    tick();
    checks++; if (bz0 !== 1'b1 || rdy0 !== 1'b1) begin errs++; $display("FAIL order_start got busy=%b rdy=%b exp 1/1", bz0, rdy0); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (sd0 !== seq_l[i]) begin errs++; $display("FAIL order_lsb_bit%0d got %b exp %b", i, sd0, seq_l[i]); end
      checks++; if (sd1 !== seq_m[i]) begin errs++; $display("FAIL order_msb_bit%0d got %b exp %b", i, sd1, seq_m[i]); end
      checks++; if (dn0 !== 1'b0) begin errs++; $display("FAIL order_early_done bit%0d got %b exp 0", i, dn0); end
      repeat (3) tick();
      checks++; if (sd0 !== seq_l[i]) begin errs++; $display("FAIL order_hold_bit%0d got %b exp %b", i, sd0, seq_l[i]); end
      strobe(0);
    end
`ifdef TX_SERIALIZER_PARITY_EN
    checks++; if (dn0 !== 1'b0 || bz0 !== 1'b1) begin errs++; $display("FAIL order_par_pending got done=%b busy=%b exp 0/1", dn0, bz0); end
    strobe(3);
`endif
    checks++; if (dn0 !== 1'b1 || dn1 !== 1'b1) begin errs++; $display("FAIL order_done got %b%b exp 11", dn0, dn1); end
    checks++; if (bz0 !== 1'b0 || sd0 !== 1'b1 || bz1 !== 1'b0 || sd1 !== 1'b1) begin errs++; $display("FAIL order_idle got busy=%b%b sd=%b%b exp 00/11", bz0, bz1, sd0, sd1); end
    tick();
    checks++; if (dn0 !== 1'b0) begin errs++; $display("FAIL order_done_pulse got %b exp 0", dn0); end
  endtask

  task automatic test_parity();
    logic [7:0] seq;
    seq = 8'b0000_0111;
    do_reset();
    load(8'h07);
    tick();
    for (int i = 0; i < 8; i++) begin
      checks++; if (sd0 !== seq[i] || sd3 !== seq[i]) begin errs++; $display("FAIL par_bit%0d got %b%b exp %b", i, sd0, sd3, seq[i]); end
      strobe(1);
    end
`ifdef TX_SERIALIZER_PARITY_EN
    checks++; if (sd0 !== 1'b1) begin errs++; $display("FAIL par_even got %b exp 1", sd0); end
    checks++; if (sd3 !== 1'b0) begin errs++; $display("FAIL par_odd got %b exp 0", sd3); end
    checks++; if (bz3 !== 1'b1 || dn0 !== 1'b0) begin errs++; $display("FAIL par_busy got busy=%b done=%b exp 1/0", bz3, dn0); end
    strobe(1);
`endif
    checks++; if (dn0 !== 1'b1 || dn3 !== 1'b1) begin errs++; $display("FAIL par_done got %b%b exp 11", dn0, dn3); end
    checks++; if (bz0 !== 1'b0 || bz3 !== 1'b0 || rdy3 !== 1'b1) begin errs++; $display("FAIL par_idle got busy=%b%b rdy=%b exp 00/1", bz0, bz3, rdy3); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] s11, s22;
    s11 = 8'h11;
    s22 = 8'h22;
    do_reset();
    load(8'h11);
    tick();
    load(8'h22);
    for (int i = 0; i < 8; i++) begin
      checks++; if (sd0 !== s11[i]) begin errs++; $display("FAIL b2b_a_bit%0d got %b exp %b", i, sd0, s11[i]); end
      checks++; if (rdy0 !== 1'b0) begin errs++; $display("FAIL b2b_ready_bit%0d got %b exp 0", i, rdy0); end
      strobe(1);
    end
`ifdef TX_SERIALIZER_PARITY_EN
    checks++; if (sd0 !== 1'b0) begin errs++; $display("FAIL b2b_a_par got %b exp 0", sd0); end
    strobe(1);
`endif
    checks++; if (dn0 !== 1'b1 || bz0 !== 1'b1) begin errs++; $display("FAIL b2b_chain got done=%b busy=%b exp 1/1", dn0, bz0); end
    checks++; if (rdy0 !== 1'b1) begin errs++; $display("FAIL b2b_ready_rise got %b exp 1", rdy0); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (sd0 !== s22[i]) begin errs++; $display("FAIL b2b_b_bit%0d got %b exp %b", i, sd0, s22[i]); end
      strobe(1);
    end
`ifdef TX_SERIALIZER_PARITY_EN
    checks++; if (sd0 !== 1'b0) begin errs++; $display("FAIL b2b_b_par got %b exp 0", sd0); end
    strobe(1);
`endif
    checks++; if (dn0 !== 1'b1 || bz0 !== 1'b0 || sd0 !== 1'b1) begin errs++; $display("FAIL b2b_end got done=%b busy=%b sd=%b exp 1/0/1", dn0, bz0, sd0); end
    tick();
    checks++; if (dn_cnt0 !== 2) begin errs++; $display("FAIL b2b_done_count got %0d exp 2", dn_cnt0); end
  endtask

  task automatic test_ser_en_high();
    logic [4:0] seq;
    seq = 5'b10110;
    do_reset();
    ser_en = 1'b1;
    repeat (3) begin
      tick();
      checks++; if (sd2 !== 1'b1 || bz2 !== 1'b0 || dn2 !== 1'b0) begin errs++; $display("FAIL en_idle got sd=%b busy=%b done=%b exp 1/0/0", sd2, bz2, dn2); end
    end
    P_DATA     = 8'h16;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    checks++; if (bz2 !== 1'b0 || rdy2 !== 1'b0) begin errs++; $display("FAIL en_accept got busy=%b rdy=%b exp 0/0", bz2, rdy2); end
    tick();
    for (int k = 0; k < 5; k++) begin
      checks++; if (sd2 !== seq[k] || bz2 !== 1'b1) begin errs++; $display("FAIL en_bit%0d got sd=%b busy=%b exp %b/1", k, sd2, bz2, seq[k]); end
      tick();
    end
`ifdef TX_SERIALIZER_PARITY_EN
    checks++; if (sd2 !== 1'b1) begin errs++; $display("FAIL en_par got %b exp 1", sd2); end
    tick();
`endif
    checks++; if (dn2 !== 1'b1 || bz2 !== 1'b0 || sd2 !== 1'b1) begin errs++; $display("FAIL en_end got done=%b busy=%b sd=%b exp 1/0/1", dn2, bz2, sd2); end
    ser_en = 1'b0;
  endtask

  task automatic test_reset_midframe();
    do_reset();
    load(8'hA5);
    tick();
    strobe(1); strobe(1); strobe(1);
    checks++; if (sd0 !== 1'b0) begin errs++; $display("FAIL mid_bit3 got %b exp 0", sd0); end
    load(8'h3C);
    checks++; if (rdy0 !== 1'b0) begin errs++; $display("FAIL mid_hold_full got %b exp 0", rdy0); end
    #2 RST = 1'b1;
    #1;
    checks++; if (sd0 !== 1'b1 || bz0 !== 1'b0 || rdy0 !== 1'b1 || dn0 !== 1'b0) begin errs++; $display("FAIL mid_rst_now got sd=%b busy=%b rdy=%b done=%b exp 1/0/1/0", sd0, bz0, rdy0, dn0); end
    tick();
    RST = 1'b0;
    repeat (3) tick();
    checks++; if (bz0 !== 1'b0 || dn_cnt0 !== 0) begin errs++; $display("FAIL mid_discard got busy=%b dones=%0d exp 0/0", bz0, dn_cnt0); end
    load(8'h01);
    tick();
    checks++; if (sd0 !== 1'b1 || bz0 !== 1'b1) begin errs++; $display("FAIL mid_restart got sd=%b busy=%b exp 1/1", sd0, bz0); end
    strobe(1);
    checks++; if (sd0 !== 1'b0) begin errs++; $display("FAIL mid_restart_bit1 got %b exp 0", sd0); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_bit_order(8'hA5, 8'b1010_0101, 8'b1010_0101);
    test_bit_order(8'h1D, 8'h1D, 8'hB8);
    test_parity();
    test_back_to_back();
    test_ser_en_high();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
